// File: rtl/finger_pkg.sv
// Shared widths, frame defaults, tracker state encoding and the IIR step helper.
package finger_pkg;

    localparam int ADDR_W     = 20;
    localparam int COORD_W    = 11;
    localparam int WIDTH_DEF  = 640;
    localparam int HEIGHT_DEF = 480;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FILTER = 2'd2,
        UPDATE = 2'd3
    } state_t;

    // One smoothing step: move f towards raw by (raw - f) >>> shift.
    // The result always lies between f and raw, so it stays inside the frame.
    function automatic logic [COORD_W-1:0] iir_step(
        input logic [COORD_W-1:0] f,
        input logic [COORD_W-1:0] raw,
        input int                 shift
    );
        logic signed [COORD_W:0] diff;
        logic signed [COORD_W:0] adj;
        logic signed [COORD_W:0] sum;
        diff = $signed({1'b0, raw}) - $signed({1'b0, f});
        adj  = diff >>> shift;
        sum  = $signed({1'b0, f}) + adj;
        return sum[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/finger_tracker_seq_divider.sv
// Restoring divider, one quotient bit per cycle. The first step is taken in
// the start cycle itself, so done rises exactly N cycles after start.
module seq_divider
    import finger_pkg::*;
#(
    parameter int N   = ADDR_W,
    parameter int D   = COORD_W,
    parameter int Q_W = COORD_W
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           i_start,
    input  logic [N-1:0]   i_dividend,
    input  logic [D-1:0]   i_divisor,
    output logic           o_done,
    output logic [Q_W-1:0] o_quotient,
    output logic [D-1:0]   o_remainder
);

    localparam int CNT_W = $clog2(N);

    logic [D-1:0]     r_rem;
    logic [N-1:0]     r_quo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_active;
    logic             r_done;

    logic [D-1:0] w_rem_in;
    logic [N-1:0] w_quo_in;
    logic [D:0]   w_trial;
    logic [D:0]   w_diff;
    logic         w_ge;
    logic [D-1:0] w_rem_nxt;
    logic [N-1:0] w_quo_nxt;

    // One restoring step on either the fresh operands or the running state.
    always_comb begin
        w_rem_in  = i_start ? '0 : r_rem;
        w_quo_in  = i_start ? i_dividend : r_quo;
        w_trial   = {w_rem_in, w_quo_in[N-1]};
        w_ge      = (w_trial >= {1'b0, i_divisor});
        w_diff    = w_trial - {1'b0, i_divisor};
        w_rem_nxt = w_ge ? w_diff[D-1:0] : w_trial[D-1:0];
        w_quo_nxt = {w_quo_in[N-2:0], w_ge};
    end

    // Iteration counter and one-cycle done strobe after the last step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem    <= w_rem_nxt;
                r_quo    <= w_quo_nxt;
                r_cnt    <= CNT_W'(N - 1);
                r_active <= 1'b1;
            end else if (r_active) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign o_done      = r_done;
    assign o_quotient  = r_quo[Q_W-1:0];
    assign o_remainder = r_rem;

endmodule

// File: rtl/finger_tracker.sv
// Finger position tracker: converts a linear pixel index into a mirrored,
// IIR-smoothed (x, y) once per camera frame and drops tracking after
// LOST_FRAMES consecutive misses.
//
// state  | meaning
// IDLE   | waiting for a rising frame_sync
// DIVIDE | divider splitting pos_in into row / column
// FILTER | smoothing new coordinates into x_out / y_out
// UPDATE | update_pulse high for this single cycle
module finger_tracker
    import finger_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int HEIGHT      = HEIGHT_DEF,
    parameter int AVG_SHIFT   = 2,
    parameter int LOST_FRAMES = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_sync,
    input  logic [ADDR_W-1:0]  pos_in,
    input  logic               found_in,
    output logic [COORD_W-1:0] x_out,
    output logic [COORD_W-1:0] y_out,
    output logic               valid_out,
    output logic               update_pulse,
    output logic               busy
);

    localparam logic [ADDR_W-1:0]  PIX_COUNT = ADDR_W'(WIDTH * HEIGHT);
    localparam logic [COORD_W-1:0] DIVISOR   = COORD_W'(WIDTH);
    localparam logic [COORD_W-1:0] X_MAX     = COORD_W'(WIDTH - 1);
    localparam int                 LOST_W    = $clog2(LOST_FRAMES + 1);
    localparam logic [LOST_W-1:0]  LOST_MAX  = LOST_W'(LOST_FRAMES);

    state_t             r_state;
    logic               r_fs_prev;
    logic               r_armed;
    logic [LOST_W-1:0]  r_lost;

    logic               w_edge;
    logic               w_hit;
    logic               w_start;
    logic               w_div_done;
    logic [COORD_W-1:0] w_div_quo;
    logic [COORD_W-1:0] w_div_rem;
    logic [COORD_W-1:0] w_x_raw;
    logic [LOST_W-1:0]  w_lost_inc;

    // r_armed blocks an edge when frame_sync is already high coming out of reset.
    assign w_edge     = frame_sync & ~r_fs_prev & r_armed;
    assign w_hit      = found_in & (pos_in < PIX_COUNT);
    assign w_start    = (r_state == IDLE) & w_edge & w_hit;
    assign w_x_raw    = X_MAX - w_div_rem;
    assign w_lost_inc = (r_lost == LOST_MAX) ? r_lost : r_lost + LOST_W'(1);
    assign busy       = (r_state != IDLE);

    seq_divider #(
        .N   (ADDR_W),
        .D   (COORD_W),
        .Q_W (COORD_W)
    ) u_div (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_start     (w_start),
        .i_dividend  (pos_in),
        .i_divisor   (DIVISOR),
        .o_done      (w_div_done),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem)
    );

    // Previous frame_sync level and arming once it has been seen low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fs_prev <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_fs_prev <= frame_sync;
            if (!frame_sync) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Tracker FSM with registered coordinates, valid flag and update strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_lost       <= '0;
            x_out        <= '0;
            y_out        <= '0;
            valid_out    <= 1'b0;
            update_pulse <= 1'b0;
        end else begin
            update_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_edge) begin
                        if (w_hit) begin
                            r_state <= DIVIDE;
                        end else begin
                            r_lost       <= w_lost_inc;
                            update_pulse <= 1'b1;
                            r_state      <= UPDATE;
                            if (w_lost_inc == LOST_MAX) begin
                                valid_out <= 1'b0;
                            end
                        end
                    end
                end
                DIVIDE: begin
                    if (w_div_done) begin
                        r_state <= FILTER;
                    end
                end
                FILTER: begin
                    if (valid_out) begin
                        x_out <= iir_step(x_out, w_x_raw, AVG_SHIFT);
                        y_out <= iir_step(y_out, w_div_quo, AVG_SHIFT);
                    end else begin
                        x_out <= w_x_raw;
                        y_out <= w_div_quo;
                    end
                    valid_out    <= 1'b1;
                    r_lost       <= '0;
                    update_pulse <= 1'b1;
                    r_state      <= UPDATE;
                end
                UPDATE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/finger_tracker.md
FINGER_TRACKER -- requirements
Module: finger_tracker

Interface
REQ-001 SHALL have parameter WIDTH, default 640, giving frame width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 480, giving frame height in pixels.
REQ-003 SHALL have parameter AVG_SHIFT, default 2, giving the IIR smoothing shift.
REQ-004 SHALL have parameter LOST_FRAMES, default 8, giving the consecutive misses before tracking drops.
REQ-005 SHALL have port clk, input, 1, the single system clock (50 MHz); all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port frame_sync, input, 1, VGA vertical sync level, synchronous to clk.
REQ-008 SHALL have port pos_in, input, 20, linear pixel index of the detected finger (row*WIDTH+col).
REQ-009 SHALL have port found_in, input, 1, finger detected in the current camera frame.
REQ-010 SHALL have port x_out, output, 11, smoothed, mirrored column.
REQ-011 SHALL have port y_out, output, 11, smoothed row.
REQ-012 SHALL have port valid_out, output, 1, finger currently tracked.
REQ-013 SHALL have port update_pulse, output, 1, one-cycle strobe when outputs change.
REQ-014 SHALL have port busy, output, 1, high when the state is not IDLE.

Function
REQ-015 SHALL detect a frame edge in cycle t, defined as frame_sync=1 with the registered previous frame_sync=0, and SHALL capture pos_in and found_in in that cycle.
REQ-016 SHALL ignore frame edges while busy=1; the in-flight computation SHALL complete unchanged.
REQ-017 SHALL use the states IDLE, DIVIDE, FILTER, UPDATE; IDLE->DIVIDE on a frame edge with found_in=1 and pos_in<WIDTH*HEIGHT; IDLE->UPDATE on any other frame edge; DIVIDE->FILTER after 20 cycles; FILTER->UPDATE; UPDATE->IDLE.
REQ-018 DIVIDE SHALL be a 20-iteration restoring division of pos_in by WIDTH, one quotient bit per cycle, producing row q and remainder r; no combinational / or % operators.
REQ-019 x_raw SHALL be WIDTH-1-r (horizontal mirror) and y_raw SHALL be q, both 11 bits.
REQ-020 FILTER: if valid_out=0, x_f and y_f SHALL load x_raw and y_raw directly; otherwise x_f SHALL become x_f+((x_raw-x_f)>>>AVG_SHIFT), with a signed 12-bit difference and arithmetic shift, and y_f likewise.
REQ-021 Found path: update_pulse SHALL be high in cycle t+22, with x_out, y_out and valid_out=1 taking their new values in the same cycle and lost counter cleared.
REQ-022 Miss path (found_in=0 or pos_in out of range): lost counter SHALL saturating-increment, update_pulse SHALL be high in cycle t+1, and x_out/y_out SHALL hold.
REQ-023 valid_out SHALL fall in the update cycle where the lost counter reaches LOST_FRAMES, and SHALL remain 0 until the next found update.
REQ-024 update_pulse SHALL be exactly one cycle wide per accepted frame edge.
REQ-025 x_out SHALL be within 0..WIDTH-1 and y_out within 0..HEIGHT-1 at all times.

Reset
REQ-026 reset_n=0 SHALL asynchronously force IDLE, x_out=0, y_out=0, valid_out=0, update_pulse=0, busy=0, lost counter=0 and the previous frame_sync register=0.
REQ-027 Reset asserted mid-DIVIDE or mid-FILTER SHALL abort the computation with no update_pulse after release.
REQ-028 If frame_sync is already high at release, no edge SHALL be seen until it falls and rises again.

Structure
REQ-029 A shared package finger_pkg SHALL hold ADDR_W=20, COORD_W=11, WIDTH/HEIGHT defaults and the state enum.
REQ-030 The division SHALL be a sub-module seq_divider with a start/done handshake, a fixed 20-cycle latency, and done high for one cycle.

Verification
REQ-031 Reset, then an edge with pos_in=0 and found_in=1 -> at t+22: x_out=639, y_out=0, valid_out=1, update_pulse=1.
REQ-032 Edge with pos_in=64040 from the untracked state -> x_out=599, y_out=100; a next edge with pos_in=64008 (raw x=631) -> x_out=607, y_out=100.
REQ-033 Edge with pos_in=307200 and found_in=1 -> treated as a miss: pulse at t+1, outputs held, lost counter=1.
REQ-034 Seven consecutive misses after tracking -> valid_out stays 1; the eighth miss -> valid_out=0 in its update cycle; the next hit loads raw values unfiltered.
REQ-035 Second frame edge at t+10 during DIVIDE -> ignored, exactly one update_pulse at t+22; reset_n pulsed low at t+5 -> all outputs 0 and no pulse.
